program_loader: RTL and testbench

// Upstream stage of the 16-bit processor. Receives a program as a byte stream

---
 rtl/program_loader.sv | 101 ++++++++++
 tb/tb_program_loader.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader: packs a byte stream into 16-bit words, writes them to imem, then starts the cpu
module program_loader #(
  parameter int MAX_WORDS = 128,
  parameter int ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              cpu_start,
  input  logic              cpu_done,
  output logic              busy,
  output logic              done,
  output logic              error
);
  localparam int IW = $clog2(MAX_WORDS);
  typedef enum logic [3:0] {IDLE, HDR_HI, HDR_LO, DAT_HI, DAT_LO, START, RUN, DONE, ERR} state_t;
  state_t            state_q, state_d;
  logic [7:0]        hi_q, hi_d;
  logic [15:0]       n_q, n_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              start_q, start_d;
  logic              xfer;
  logic [15:0]       hdr;
  assign in_ready   = state_q inside {HDR_HI, HDR_LO, DAT_HI, DAT_LO};
  assign busy       = !(state_q inside {IDLE, DONE, ERR});
  assign done       = state_q == DONE;
  assign error      = state_q == ERR;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_start  = start_q;
  assign xfer       = in_valid & in_ready;
  assign hdr        = {hi_q, in_data};
  // State register and write/start strobes; reset aborts everything at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hi_q    <= '0;
      n_q     <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      start_q <= start_d;
    end
  end
  // Next state: header check, byte pairing, one-cycle-late write and start pulse
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    n_d     = n_q;
    idx_d   = idx_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    start_d = state_q == START;
    case (state_q)
      IDLE, DONE, ERR: state_d = go ? HDR_HI : state_q;
      HDR_HI, DAT_HI: if (xfer) begin
        hi_d    = in_data;
        state_d = state_q == HDR_HI ? HDR_LO : DAT_LO;
      end
      HDR_LO: if (xfer) begin
        n_d     = hdr;
        idx_d   = '0;
        state_d = (hdr == 16'd0 || hdr > 16'(MAX_WORDS)) ? ERR : DAT_HI;
      end
      DAT_LO: if (xfer) begin
        we_d    = 1'b1;
        addr_d  = ADDR_W'({idx_q, 1'b0});
        wdata_d = hdr;
        if (16'(idx_q) + 16'd1 == n_q) state_d = START;
        else begin
          idx_d   = idx_q + IW'(1);
          state_d = DAT_HI;
        end
      end
      START:   state_d = RUN;
      RUN:     state_d = cpu_done ? DONE : RUN;
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed checks of the byte-stream program loader
module tb_program_loader;
  logic        clk = 0, rst = 1, go = 0, in_valid = 0, cpu_done = 0;
  logic [7:0]  in_data = 0;
  logic        in_ready, imem_we, cpu_start, busy, done, error;
  logic [15:0] imem_addr, imem_wdata;
  int errors = 0, checks = 0;
  int cyc = 0, wr_n = 0, st_n = 0, last_we_cyc = 0, st_cyc = 0;
  logic [15:0] wr_addr [512];
  logic [15:0] wr_data [512];
  logic chk_rdy = 0;
  int wb, sb;

  program_loader #(.MAX_WORDS(128), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst), .go(go), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_start(cpu_start), .cpu_done(cpu_done),
    .busy(busy), .done(done), .error(error));

  always #5 clk = ~clk;

  // Record every write and start pulse mid-cycle
  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr[wr_n] <= imem_addr;
      wr_data[wr_n] <= imem_wdata;
      wr_n <= wr_n + 1;
      last_we_cyc <= cyc;
    end
    if (cpu_start) begin
      st_n <= st_n + 1;
      st_cyc <= cyc;
    end
    cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) begin
      in_valid = 0;
      tick(1);
      if (chk_rdy) chk("rdy_gap", in_ready, 1);
    end
    in_valid = 1;
    in_data = b;
    t = 0;
    while (!in_ready && t < 50) begin tick(1); t++; end
    if (t >= 50) chk("ready_timeout", 0, 1);
    tick(1);
    in_valid = 0;
  endtask

  task automatic do_go();
    go = 1;
    tick(1);
    go = 0;
  endtask

  task automatic send_prog(input int gap);
    send(8'h00, gap); send(8'h02, gap);
    send(8'h12, gap); send(8'h34, gap);
    send(8'hAB, gap); send(8'hCD, gap);
  endtask

  task automatic check_prog(input string tag);
    tick(3);
    chk({tag, "_nwr"}, wr_n - wb, 2);
    chk({tag, "_a0"}, wr_addr[wb], 16'h0000);
    chk({tag, "_d0"}, wr_data[wb], 16'h1234);
    chk({tag, "_a1"}, wr_addr[wb+1], 16'h0002);
    chk({tag, "_d1"}, wr_data[wb+1], 16'hABCD);
    chk({tag, "_nst"}, st_n - sb, 1);
    chk({tag, "_stlat"}, st_cyc - last_we_cyc, 1);
    chk({tag, "_busy_run"}, busy, 1);
    chk({tag, "_done_run"}, done, 0);
  endtask

  task automatic finish_cpu(input string tag);
    cpu_done = 1;
    tick(1);
    cpu_done = 0;
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    tick(3);
    chk("rst_outs", |{in_ready, imem_we, imem_addr, imem_wdata, cpu_start, busy, done, error}, 0);
    rst = 0;
    tick(2);
    chk("idle_ready", in_ready, 0);

    // 1: back-to-back load
    wb = wr_n; sb = st_n;
    do_go();
    chk("t1_busy", busy, 1);
    send_prog(0);
    check_prog("t1");
    finish_cpu("t1");

    // 2: 3-cycle gaps between bytes
    wb = wr_n; sb = st_n;
    do_go();
    chk("t2_done_clr", done, 0);
    chk_rdy = 1;
    send_prog(3);
    chk_rdy = 0;
    check_prog("t2");
    finish_cpu("t2");

    // 3: bad headers
    wb = wr_n; sb = st_n;
    do_go();
    send(8'h00, 0); send(8'h00, 0);
    chk("t3_err0", error, 1);
    chk("t3_busy0", busy, 0);
    do_go();
    chk("t3_err_clr", error, 0);
    chk("t3_rdy", in_ready, 1);
    send(8'h00, 0); send(8'h81, 0);
    chk("t3_err129", error, 1);
    tick(3);
    chk("t3_nwr", wr_n - wb, 0);
    chk("t3_nst", st_n - sb, 0);

    // 4: maximum length program
    wb = wr_n; sb = st_n;
    do_go();
    send(8'h00, 0); send(8'h80, 0);
    for (int k = 0; k < 128; k++) begin
      send(8'h00, 0);
      send(8'(k), 0);
    end
    tick(3);
    chk("t4_nwr", wr_n - wb, 128);
    chk("t4_a5", wr_addr[wb+5], 16'h000A);
    chk("t4_d5", wr_data[wb+5], 16'h0005);
    chk("t4_alast", wr_addr[wb+127], 16'h00FE);
    chk("t4_dlast", wr_data[wb+127], 16'h007F);
    chk("t4_nst", st_n - sb, 1);
    finish_cpu("t4");

    // 5: reset mid-load, then reload
    do_go();
    send(8'h00, 0); send(8'h02, 0);
    send(8'h12, 0); send(8'h34, 0); send(8'hAB, 0);
    chk("t5_pre_wdata", imem_wdata, 16'h1234);
    rst = 1;
    #1;
    chk("t5_rst_outs", |{in_ready, imem_we, imem_addr, imem_wdata, cpu_start, busy, done, error}, 0);
    tick(1);
    rst = 0;
    tick(1);
    wb = wr_n; sb = st_n;
    do_go();
    send_prog(0);
    check_prog("t5");
    finish_cpu("t5");

    // 6: cpu_done and go during DAT_LO are ignored
    wb = wr_n; sb = st_n;
    do_go();
    send(8'h00, 0); send(8'h02, 0);
    send(8'h12, 0); send(8'h34, 0); send(8'hAB, 0);
    cpu_done = 1; go = 1;
    tick(1);
    cpu_done = 0; go = 0;
    chk("t6_busy", busy, 1);
    chk("t6_done", done, 0);
    chk("t6_rdy", in_ready, 1);
    send(8'hCD, 0);
    check_prog("t6");
    finish_cpu("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
